exe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the EXE stage and its neighbouring pipeline registers. It holds EXE for the multi-cycle multiply and inserts a load-use interlock bubble. It also flushes the two younger stages on a taken BEQZ/BNEQZ and freezes the pipe on HALT. The block is pure control: it drives stall, flush and hold enables of the PC, IF/ID and ID/EX registers and does not touch data.

---
 rtl/exe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_exe_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage sequencing: MUL hold, load-use interlock,
// taken-branch flush and HALT freeze for PC, IF/ID and ID/EX.
module exe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int REG_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_id,
  input  logic        id_valid,
  input  logic [31:0] ir_ex,
  input  logic        ex_valid,
  input  logic        br_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_bubble,
  output logic        halted
);

  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 2);

  typedef enum logic [1:0] {
    S_RUN,
    S_MUL,
    S_HALT
  } state_t;

  state_t     state, state_n;
  logic [3:0] mul_cnt, cnt_n;

  logic [5:0]       op_id, op_ex;
  logic [REG_W-1:0] rs_id, rt_id, rt_ex;
  logic             rs_used, rt_used;
  logic             ex_halt, ex_br, ex_mul, ex_lw;
  logic             halt_ev, br_ev, mul_ev, lu_ev;
  logic             unused;

  assign op_id = ir_id[31:26];
  assign op_ex = ir_ex[31:26];
  assign rs_id = ir_id[25 -: REG_W];
  assign rt_id = ir_id[20 -: REG_W];
  assign rt_ex = ir_ex[20 -: REG_W];
  assign unused = ^{ir_id[15:0], ir_ex[25:21], ir_ex[15:0]};

  assign rs_used = (op_id != OP_HALT);
  assign rt_used = (op_id[5:4] == 2'b00) || (op_id == OP_SW);

  assign ex_halt = (op_ex == OP_HALT);
  assign ex_br   = (op_ex[5:1] == 5'b11010);
  assign ex_mul  = !op_ex[5] && (op_ex[3:0] == 4'd2);
  assign ex_lw   = (op_ex == OP_LW);

  assign halt_ev = ex_valid && ex_halt;
  assign br_ev   = ex_valid && ex_br && br_taken;
  assign mul_ev  = ex_valid && ex_mul && (MUL_LAT > 1);
  assign lu_ev   = ex_valid && ex_lw && id_valid &&
                   (rt_ex != '0) &&
                   ((rs_used && rs_id == rt_ex) ||
                    (rt_used && rt_id == rt_ex));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_n;
      mul_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = mul_cnt;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    halted       = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_RUN: begin
          if (halt_ev) begin
            state_n    = S_HALT;
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (br_ev) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (mul_ev) begin
            state_n      = S_MUL;
            cnt_n        = MUL_INIT;
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
          end else if (lu_ev) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        S_MUL: begin
          // count 0 is the final EXE cycle: result leaves this cycle
          if (mul_cnt != '0) begin
            cnt_n        = mul_cnt - 4'd1;
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
          end else begin
            state_n = S_RUN;
          end
        end
        S_HALT: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          halted     = 1'b1;
        end
        default: begin
          state_n = S_RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl with MUL_LAT=4.
// Outputs packed {pc_st,ifid_st,ifid_fl,idex_st,idex_fl,exmem_bub,halted}.
module tb_exe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir_id, ir_ex;
  logic        id_valid, ex_valid, br_taken;
  logic        pc_stall, ifid_stall, ifid_flush;
  logic        idex_stall, idex_flush, exmem_bubble, halted;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] Z    = 7'b0000000;
  localparam logic [6:0] MULS = 7'b1101010;
  localparam logic [6:0] LUS  = 7'b1100100;
  localparam logic [6:0] BRF  = 7'b0010100;
  localparam logic [6:0] HLT0 = 7'b1010100;
  localparam logic [6:0] HLTD = 7'b1101001;

  localparam logic [31:0] I_MUL   = {6'b000010, 5'd1, 5'd2, 5'd3, 11'd0};
  localparam logic [31:0] I_LW5   = {6'b100000, 5'd1, 5'd5, 16'd0};
  localparam logic [31:0] I_LW0   = {6'b100000, 5'd1, 5'd0, 16'd0};
  localparam logic [31:0] I_ADD5  = {6'b000000, 5'd5, 5'd6, 5'd7, 11'd0};
  localparam logic [31:0] I_ADDT5 = {6'b000000, 5'd6, 5'd5, 5'd7, 11'd0};
  localparam logic [31:0] I_ADD0  = {6'b000000, 5'd0, 5'd0, 5'd7, 11'd0};
  localparam logic [31:0] I_ADDI  = {6'b010000, 5'd7, 5'd5, 16'd0};
  localparam logic [31:0] I_SW5   = {6'b100001, 5'd1, 5'd5, 16'd0};
  localparam logic [31:0] I_HLT5  = {6'b111111, 5'd5, 21'd0};
  localparam logic [31:0] I_BEQZ  = {6'b110100, 5'd4, 21'd0};
  localparam logic [31:0] I_BNEQZ = {6'b110101, 5'd4, 21'd0};
  localparam logic [31:0] I_HALT  = {6'b111111, 26'd0};
  localparam logic [31:0] I_NOP   = {6'b000000, 5'd1, 5'd2, 5'd3, 11'd0};

  exe_hazard_ctrl #(.MUL_LAT(4), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ir_id(ir_id), .id_valid(id_valid),
    .ir_ex(ir_ex), .ex_valid(ex_valid),
    .br_taken(br_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .idex_flush(idex_flush), .exmem_bubble(exmem_bubble),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall,
            idex_flush, exmem_bubble, halted};
  endfunction

  task automatic drive(input logic [31:0] ex, input logic ev,
                       input logic [31:0] id, input logic iv,
                       input logic bt);
    ir_ex = ex; ex_valid = ev;
    ir_id = id; id_valid = iv;
    br_taken = bt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(I_HALT, 1'b1, I_ADD5, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (outs() !== Z) begin
        errors++;
        $display("FAIL reset_low c%0d got=%b exp=%b", i, outs(), Z);
      end
      checks++;
      next_cycle();
    end
    rst_n = 1'b1;
    drive(I_NOP, 1'b0, I_NOP, 1'b0, 1'b0);
    @(negedge clk);
    if (outs() !== Z) begin
      errors++;
      $display("FAIL reset_after got=%b exp=%b", outs(), Z);
    end
    checks++;
    next_cycle();
  endtask

  task automatic test_mul_timing();
    logic [6:0] exp [5] = '{MULS, MULS, MULS, Z, Z};
    drive(I_MUL, 1'b1, I_ADD5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) drive(I_NOP, 1'b1, I_NOP, 1'b1, 1'b0);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL mul_timing c%0d got=%b exp=%b",
                 i + 1, outs(), exp[i]);
      end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp [9] =
      '{MULS, MULS, MULS, Z, MULS, MULS, MULS, Z, Z};
    drive(I_MUL, 1'b1, I_NOP, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) drive(I_NOP, 1'b1, I_NOP, 1'b1, 1'b0);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL mul_b2b c%0d got=%b exp=%b",
                 i, outs(), exp[i]);
      end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(I_MUL, 1'b1, I_NOP, 1'b1, 1'b0);
    @(negedge clk);
    if (outs() !== MULS) begin
      errors++;
      $display("FAIL rmul_c1 got=%b exp=%b", outs(), MULS);
    end
    checks++;
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    if (outs() !== Z) begin
      errors++;
      $display("FAIL rmul_c2 got=%b exp=%b", outs(), Z);
    end
    checks++;
    next_cycle();
    rst_n = 1'b1;
    drive(I_NOP, 1'b0, I_NOP, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (outs() !== Z) begin
        errors++;
        $display("FAIL rmul_after c%0d got=%b exp=%b", i, outs(), Z);
      end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ids [7] =
      '{I_ADD5, I_ADDI, I_ADDT5, I_SW5, I_HLT5, I_ADD5, I_ADD5};
    logic        ivs [7] = '{1, 1, 1, 1, 1, 0, 1};
    logic [31:0] exs [7] =
      '{I_LW5, I_LW5, I_LW5, I_LW5, I_LW5, I_LW5, I_LW0};
    logic [6:0]  exp [7] = '{LUS, Z, LUS, LUS, Z, Z, Z};
    for (int i = 0; i < 7; i++) begin
      drive(exs[i], 1'b1, ids[i], ivs[i], 1'b0);
      if (i == 6) ir_id = I_ADD0;
      @(negedge clk);
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL load_use v%0d got=%b exp=%b",
                 i, outs(), exp[i]);
      end
      checks++;
      next_cycle();
      // ID/EX was flushed: bubble in EXE, same ID instruction
      drive(I_NOP, 1'b0, ids[i], ivs[i], 1'b0);
      @(negedge clk);
      if (outs() !== Z) begin
        errors++;
        $display("FAIL load_use_next v%0d got=%b exp=%b",
                 i, outs(), Z);
      end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_branch();
    logic [31:0] exs [5] = '{I_BEQZ, I_BEQZ, I_BNEQZ, I_BNEQZ, I_BEQZ};
    logic        bts [5] = '{1, 0, 1, 0, 1};
    logic [6:0]  exp [5] = '{BRF, Z, BRF, Z, BRF};
    for (int i = 0; i < 5; i++) begin
      drive(exs[i], 1'b1, I_ADD5, 1'b1, bts[i]);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL branch v%0d got=%b exp=%b",
                 i, outs(), exp[i]);
      end
      checks++;
      next_cycle();
    end
    drive(I_NOP, 1'b0, I_ADD5, 1'b1, 1'b0);
    @(negedge clk);
    if (outs() !== Z) begin
      errors++;
      $display("FAIL branch_after got=%b exp=%b", outs(), Z);
    end
    checks++;
    next_cycle();
  endtask

  task automatic test_suppress();
    logic [31:0] exs [4] = '{I_MUL, I_LW5, I_BEQZ, I_HALT};
    for (int i = 0; i < 4; i++) begin
      drive(exs[i], 1'b0, I_ADD5, 1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (outs() !== Z) begin
          errors++;
          $display("FAIL suppress v%0d c%0d got=%b exp=%b",
                   i, c, outs(), Z);
        end
        checks++;
        next_cycle();
      end
    end
  endtask

  task automatic test_halt();
    drive(I_HALT, 1'b1, I_ADD5, 1'b1, 1'b0);
    @(negedge clk);
    if (outs() !== HLT0) begin
      errors++;
      $display("FAIL halt_c0 got=%b exp=%b", outs(), HLT0);
    end
    checks++;
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      drive($urandom, 1'($urandom), $urandom,
            1'($urandom), 1'($urandom));
      if (i == 3) drive(I_MUL, 1'b1, I_NOP, 1'b1, 1'b0);
      if (i == 5) drive(I_BEQZ, 1'b1, I_NOP, 1'b1, 1'b1);
      if (i == 7) drive(I_LW5, 1'b1, I_ADD5, 1'b1, 1'b0);
      @(negedge clk);
      if (outs() !== HLTD) begin
        errors++;
        $display("FAIL halt_hold c%0d got=%b exp=%b",
                 i + 1, outs(), HLTD);
      end
      checks++;
      next_cycle();
    end
    rst_n = 1'b0;
    @(negedge clk);
    if (outs() !== Z) begin
      errors++;
      $display("FAIL halt_rst got=%b exp=%b", outs(), Z);
    end
    checks++;
    next_cycle();
    rst_n = 1'b1;
    drive(I_NOP, 1'b1, I_NOP, 1'b1, 1'b0);
    @(negedge clk);
    if (outs() !== Z) begin
      errors++;
      $display("FAIL halt_release got=%b exp=%b", outs(), Z);
    end
    checks++;
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(I_NOP, 1'b0, I_NOP, 1'b0, 1'b0);
    next_cycle();
    test_reset();
    test_mul_timing();
    test_back_to_back();
    test_reset_mid_mul();
    test_load_use();
    test_branch();
    test_suppress();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
